// File: rtl/xs3_bcd_seq.sv
// Multi-digit Excess-3 to BCD sequencer: one shared digit converter, MSD first,
// producing packed BCD, the binary value and the first invalid-digit position.
module xs3_bcd_seq #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [4*DIGITS-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*DIGITS-1:0]       out_bcd,
    output logic [BIN_W-1:0]          out_bin,
    output logic                      out_err,
    output logic [$clog2(DIGITS)-1:0] out_err_idx,
    output logic                      busy
);

    localparam int DW = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS);
    localparam int AW = BIN_W + 4;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t            state_reg, state_next;
    logic [DW-1:0]     shift_reg;
    logic [BIN_W-1:0]  acc_reg;
    logic              err_reg;
    logic [IW-1:0]     err_idx_reg;
    logic [IW-1:0]     cnt_reg;
    logic [DW-1:0]     bcd_all;

    logic              accept;
    logic              step;
    logic [3:0]        digit;
    logic              digit_ok;
    logic [3:0]        digit_bcd;
    logic [3:0]        digit_val;
    logic [IW-1:0]     k;
    logic [AW-1:0]     acc_x10;
    logic [AW-1:0]     acc_sum;

    assign accept    = (state_reg == IDLE) && in_valid;
    assign step      = (state_reg == CONV);
    // The shift register always presents the digit under conversion in its top nibble.
    assign digit     = shift_reg[DW-1 -: 4];
    assign digit_ok  = (digit >= 4'd3) && (digit <= 4'd12);
    assign digit_bcd = digit_ok ? (digit - 4'd3) : 4'hF;
    assign digit_val = digit_ok ? (digit - 4'd3) : 4'd0;
    assign k         = LAST - cnt_reg;

    assign acc_x10 = ({4'b0000, acc_reg} << 3) + ({4'b0000, acc_reg} << 1);
    assign acc_sum = acc_x10 + AW'(digit_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (cnt_reg == LAST) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            acc_reg     <= '0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
            cnt_reg     <= '0;
        end else if (accept) begin
            shift_reg   <= in_data;
            acc_reg     <= '0;
            err_reg     <= 1'b0;
            err_idx_reg <= '0;
            cnt_reg     <= '0;
        end else if (step) begin
            shift_reg <= shift_reg << 4;
            acc_reg   <= acc_sum[BIN_W-1:0];
            if (!digit_ok && !err_reg) begin
                err_reg     <= 1'b1;
                err_idx_reg <= k;
            end
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    // Each result nibble has its own register, loaded only on the edge converting that digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            logic [3:0] nib_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    nib_reg <= 4'h0;
                end else if (step && (k == IW'(gi))) begin
                    nib_reg <= digit_bcd;
                end
            end
            assign bcd_all[4*gi +: 4] = nib_reg;
        end
    endgenerate

    assign out_bcd     = bcd_all;
    assign out_bin     = acc_reg;
    assign out_err     = err_reg;
    assign out_err_idx = err_idx_reg;

endmodule
